// File: rtl/gpio_irq_ctrl_pkg.sv
// gpio_irq_ctrl_pkg
//   Shared constants for the GPIO interrupt controller. The register offsets
//   and the DEBOUNCE field width live here so that software headers for the
//   GPIO block can be generated from the same values the RTL decodes.
//   Also provides the register selector enum and the offset decoder used by
//   the top level.
package gpio_irq_ctrl_pkg;

  localparam logic [7:0] OFF_IRQ_ENABLE = 8'h00;
  localparam logic [7:0] OFF_EDGE_RISE  = 8'h04;
  localparam logic [7:0] OFF_EDGE_FALL  = 8'h08;
  localparam logic [7:0] OFF_PENDING    = 8'h0C;
  localparam logic [7:0] OFF_PIN_STATE  = 8'h10;
  localparam logic [7:0] OFF_DEBOUNCE   = 8'h14;

  localparam int DEBOUNCE_W = 16;

  typedef enum logic [2:0] {
    REG_IRQ_ENABLE,
    REG_EDGE_RISE,
    REG_EDGE_FALL,
    REG_PENDING,
    REG_PIN_STATE,
    REG_DEBOUNCE,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [7:0] off);
    reg_sel_e sel;
    case (off)
      OFF_IRQ_ENABLE: sel = REG_IRQ_ENABLE;
      OFF_EDGE_RISE:  sel = REG_EDGE_RISE;
      OFF_EDGE_FALL:  sel = REG_EDGE_FALL;
      OFF_PENDING:    sel = REG_PENDING;
      OFF_PIN_STATE:  sel = REG_PIN_STATE;
      OFF_DEBOUNCE:   sel = REG_DEBOUNCE;
      default:        sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/gpio_irq_ctrl_filter.sv
// gpio_filter
//   Per-pin input conditioning: a 2-flop synchronizer followed by a 2-deep
//   history sampled on the shared debounce tick. The filtered level only
//   follows the synchronized value once it has been identical on three
//   consecutive ticks, so shorter pulses are rejected.
// Ports
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   tick_i  : debounce sample strobe, one cycle wide
//   pin_i   : raw asynchronous pin level
//   level_o : filtered pin level
//   rise_o  : filtered level is changing 0->1 on this edge
//   fall_o  : filtered level is changing 1->0 on this edge
module gpio_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic h0_q, h0_d;
  logic h1_q, h1_d;
  logic level_q, level_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      h0_q    <= 1'b0;
      h1_q    <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      level_q <= level_d;
    end
  end

  // The synchronizer runs every cycle; history and level move only on ticks.
  // rise/fall are asserted in the same cycle the level register is loaded so
  // the pending logic captures the event on the very edge the level changes.
  always_comb begin
    sync1_d = pin_i;
    sync2_d = sync1_q;
    h0_d    = h0_q;
    h1_d    = h1_q;
    level_d = level_q;
    rise_o  = 1'b0;
    fall_o  = 1'b0;
    if (tick_i) begin
      h0_d = sync2_q;
      h1_d = h0_q;
      if ((sync2_q == h0_q) && (h0_q == h1_q) && (sync2_q != level_q)) begin
        level_d = sync2_q;
        rise_o  = sync2_q;
        fall_o  = ~sync2_q;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// gpio_irq_ctrl
//   Edge-triggered interrupt controller for GPIO input pins. Each pin is
//   synchronized and debounced, filtered edges selected by EDGE_RISE and
//   EDGE_FALL latch into a W1C PENDING register, and irq_o is a registered
//   OR of PENDING masked by IRQ_ENABLE.
// Ports
//   clk             : clock
//   rst_n           : asynchronous active-low reset
//   pins_i          : raw pin levels, asynchronous to clk
//   read_request_i  : bus read strobe
//   write_request_i : bus write strobe
//   address_i       : byte address, bits [7:0] decoded
//   write_data_i    : bus write data
//   read_data_o     : combinational read data, zero when not reading
//   response_o      : zero-wait-state acknowledge
//   irq_o           : level interrupt
module gpio_irq_ctrl
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins_i,
  input  logic             read_request_i,
  input  logic             write_request_i,
  input  logic [31:0]      address_i,
  input  logic [31:0]      write_data_i,
  output logic [31:0]      read_data_o,
  output logic             response_o,
  output logic             irq_o
);

  logic [WIDTH-1:0]      irq_enable_q, irq_enable_d;
  logic [WIDTH-1:0]      edge_rise_q, edge_rise_d;
  logic [WIDTH-1:0]      edge_fall_q, edge_fall_d;
  logic [WIDTH-1:0]      pending_q, pending_d;
  logic [DEBOUNCE_W-1:0] debounce_q, debounce_d;
  logic [DEBOUNCE_W-1:0] presc_q, presc_d;
  logic                  irq_q, irq_d;

  logic                  tick;
  logic [WIDTH-1:0]      level_vec;
  logic [WIDTH-1:0]      rise_vec;
  logic [WIDTH-1:0]      fall_vec;
  logic [WIDTH-1:0]      event_vec;
  logic [WIDTH-1:0]      w1c_mask;
  reg_sel_e              sel;
  logic                  unused_bits;

  assign sel         = decode_offset(address_i[7:0]);
  assign tick        = (presc_q == debounce_q);
  assign event_vec   = (rise_vec & edge_rise_q) | (fall_vec & edge_fall_q);
  assign response_o  = read_request_i | write_request_i;
  assign irq_o       = irq_q;
  assign unused_bits = ^{address_i[31:8], write_data_i};

  for (genvar i = 0; i < WIDTH; i++) begin : g_filter
    gpio_filter u_filter (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_i  (tick),
      .pin_i   (pins_i[i]),
      .level_o (level_vec[i]),
      .rise_o  (rise_vec[i]),
      .fall_o  (fall_vec[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_enable_q <= '0;
      edge_rise_q  <= '0;
      edge_fall_q  <= '0;
      pending_q    <= '0;
      debounce_q   <= '0;
      presc_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      irq_enable_q <= irq_enable_d;
      edge_rise_q  <= edge_rise_d;
      edge_fall_q  <= edge_fall_d;
      pending_q    <= pending_d;
      debounce_q   <= debounce_d;
      presc_q      <= presc_d;
      irq_q        <= irq_d;
    end
  end

  // Register writes, W1C pending with set-over-clear priority, prescaler and
  // the registered interrupt. A DEBOUNCE write restarts the prescaler so the
  // new period starts cleanly from zero.
  always_comb begin
    irq_enable_d = irq_enable_q;
    edge_rise_d  = edge_rise_q;
    edge_fall_d  = edge_fall_q;
    debounce_d   = debounce_q;
    w1c_mask     = '0;
    presc_d      = tick ? '0 : presc_q + DEBOUNCE_W'(1);
    if (write_request_i) begin
      case (sel)
        REG_IRQ_ENABLE: irq_enable_d = write_data_i[WIDTH-1:0];
        REG_EDGE_RISE:  edge_rise_d  = write_data_i[WIDTH-1:0];
        REG_EDGE_FALL:  edge_fall_d  = write_data_i[WIDTH-1:0];
        REG_PENDING:    w1c_mask     = write_data_i[WIDTH-1:0];
        REG_DEBOUNCE: begin
          debounce_d = write_data_i[DEBOUNCE_W-1:0];
          presc_d    = '0;
        end
        default: ;
      endcase
    end
    pending_d = (pending_q & ~w1c_mask) | event_vec;
    irq_d     = |(pending_q & irq_enable_q);
  end

  // Read mux; narrower registers are zero-extended to the bus width.
  always_comb begin
    read_data_o = '0;
    if (read_request_i) begin
      case (sel)
        REG_IRQ_ENABLE: read_data_o[WIDTH-1:0]      = irq_enable_q;
        REG_EDGE_RISE:  read_data_o[WIDTH-1:0]      = edge_rise_q;
        REG_EDGE_FALL:  read_data_o[WIDTH-1:0]      = edge_fall_q;
        REG_PENDING:    read_data_o[WIDTH-1:0]      = pending_q;
        REG_PIN_STATE:  read_data_o[WIDTH-1:0]      = level_vec;
        REG_DEBOUNCE:   read_data_o[DEBOUNCE_W-1:0] = debounce_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb_gpio_irq_ctrl
//   Directed self-checking bench for gpio_irq_ctrl with WIDTH=20. Each task
//   covers one scenario and compares against hand-computed values.
module tb_gpio_irq_ctrl;
  import gpio_irq_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [19:0] pins_i;
  logic        read_request_i;
  logic        write_request_i;
  logic [31:0] address_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        response_o;
  logic        irq_o;

  int n_compared;
  int n_mismatched;

  gpio_irq_ctrl #(.WIDTH(20)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pins_i          (pins_i),
    .read_request_i  (read_request_i),
    .write_request_i (write_request_i),
    .address_i       (address_i),
    .write_data_i    (write_data_i),
    .read_data_o     (read_data_o),
    .response_o      (response_o),
    .irq_o           (irq_o)
  );

  always #5 clk = ~clk;

  // Advance n full cycles, ending at a falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One-cycle write strobe; the register updates on the enclosed rising edge.
  task automatic bus_write(input logic [7:0] off, input logic [31:0] data);
    address_i       = {24'h0, off};
    write_data_i    = data;
    write_request_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    write_request_i = 1'b0;
    write_data_i    = 32'h0;
  endtask

  // Combinational read taken between clock edges.
  task automatic bus_read(input logic [7:0] off, output logic [31:0] data);
    address_i      = {24'h0, off};
    read_request_i = 1'b1;
    #1;
    data           = read_data_o;
    read_request_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #1;
    n_compared++;
    if (irq_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_irq: got %b want 0", irq_o);
    end
    n_compared++;
    if (response_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_response: got %b want 0", response_o);
    end
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_pending: got %h want 0", rd);
    end
    bus_read(OFF_DEBOUNCE, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_debounce: got %h want 0", rd);
    end
    @(negedge clk);
    step(2);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic_rise();
    logic [31:0] rd;
    bus_write(OFF_IRQ_ENABLE, 32'h1);
    bus_write(OFF_EDGE_RISE, 32'h1);
    bus_write(OFF_DEBOUNCE, 32'h0);
    step(3);
    pins_i[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      bus_read(OFF_PENDING, rd);
      n_compared++;
      if (rd !== ((e >= 5) ? 32'h1 : 32'h0)) begin
        n_mismatched++;
        $display("[TB] FAIL rise_pending_edge%0d: got %h want %h", e, rd,
                 (e >= 5) ? 32'h1 : 32'h0);
      end
      n_compared++;
      if (irq_o !== ((e >= 6) ? 1'b1 : 1'b0)) begin
        n_mismatched++;
        $display("[TB] FAIL rise_irq_edge%0d: got %b want %b", e, irq_o, (e >= 6));
      end
    end
    bus_read(OFF_PIN_STATE, rd);
    n_compared++;
    if (rd !== 32'h1) begin
      n_mismatched++;
      $display("[TB] FAIL rise_pin_state: got %h want 1", rd);
    end
    bus_write(OFF_PENDING, 32'h1);
    step(2);
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    bus_write(OFF_EDGE_RISE, 32'h8);
    bus_write(OFF_DEBOUNCE, 32'h3);
    step(1);
    pins_i[3] = 1'b1;
    step(2);
    pins_i[3] = 1'b0;
    step(20);
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL glitch_pending: got %h want 0", rd);
    end
    bus_read(OFF_PIN_STATE, rd);
    n_compared++;
    if (rd !== 32'h1) begin
      n_mismatched++;
      $display("[TB] FAIL glitch_pin_state: got %h want 1", rd);
    end
    pins_i[3] = 1'b1;
    step(20);
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h8) begin
      n_mismatched++;
      $display("[TB] FAIL long_pending: got %h want 8", rd);
    end
    bus_read(OFF_PIN_STATE, rd);
    n_compared++;
    if (rd !== 32'h9) begin
      n_mismatched++;
      $display("[TB] FAIL long_pin_state: got %h want 9", rd);
    end
    bus_write(OFF_PENDING, 32'h8);
    bus_write(OFF_DEBOUNCE, 32'h0);
    step(2);
  endtask

  task automatic test_fall_masked();
    logic [31:0] rd;
    pins_i[2] = 1'b1;
    step(10);
    bus_write(OFF_EDGE_FALL, 32'h4);
    bus_write(OFF_IRQ_ENABLE, 32'h0);
    pins_i[2] = 1'b0;
    step(10);
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h4) begin
      n_mismatched++;
      $display("[TB] FAIL fall_pending: got %h want 4", rd);
    end
    n_compared++;
    if (irq_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL fall_irq_masked: got %b want 0", irq_o);
    end
    bus_write(OFF_IRQ_ENABLE, 32'h4);
    n_compared++;
    if (irq_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL enable_irq_same_edge: got %b want 0", irq_o);
    end
    step(1);
    n_compared++;
    if (irq_o !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL enable_irq_next: got %b want 1", irq_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    pins_i[2] = 1'b1;
    step(8);
    bus_write(OFF_PENDING, 32'h4);
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL w1c_clear: got %h want 0", rd);
    end
    pins_i[2] = 1'b0;
    step(4);
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL pre_event_pending: got %h want 0", rd);
    end
    bus_write(OFF_PENDING, 32'h4);
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h4) begin
      n_mismatched++;
      $display("[TB] FAIL set_wins: got %h want 4", rd);
    end
    step(1);
    bus_write(OFF_PENDING, 32'h4);
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL w1c_alone: got %h want 0", rd);
    end
    n_compared++;
    if (irq_o !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL irq_after_clear_edge: got %b want 1", irq_o);
    end
    step(1);
    n_compared++;
    if (irq_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL irq_drop: got %b want 0", irq_o);
    end
  endtask

  task automatic test_bus();
    logic [31:0] rd;
    bus_read(8'h18, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL unmapped_read: got %h want 0", rd);
    end
    address_i      = {24'h0, OFF_PIN_STATE};
    read_request_i = 1'b0;
    #1;
    n_compared++;
    if (read_data_o !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL no_strobe_read: got %h want 0", read_data_o);
    end
    n_compared++;
    if (response_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_response: got %b want 0", response_o);
    end
    read_request_i = 1'b1;
    #1;
    n_compared++;
    if (response_o !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL read_response: got %b want 1", response_o);
    end
    read_request_i  = 1'b0;
    write_request_i = 1'b1;
    write_data_i    = 32'h0;
    #1;
    n_compared++;
    if (response_o !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL write_response: got %b want 1", response_o);
    end
    @(posedge clk);
    @(negedge clk);
    write_request_i = 1'b0;
    bus_read(OFF_PIN_STATE, rd);
    n_compared++;
    if (rd !== 32'h9) begin
      n_mismatched++;
      $display("[TB] FAIL ro_write_ignored: got %h want 9", rd);
    end
    bus_write(OFF_IRQ_ENABLE, 32'hFFFF_FFFF);
    bus_read(OFF_IRQ_ENABLE, rd);
    n_compared++;
    if (rd !== 32'h000F_FFFF) begin
      n_mismatched++;
      $display("[TB] FAIL enable_upper_bits: got %h want 000fffff", rd);
    end
    bus_write(OFF_DEBOUNCE, 32'hFFFF_FFFF);
    bus_read(OFF_DEBOUNCE, rd);
    n_compared++;
    if (rd !== 32'h0000_FFFF) begin
      n_mismatched++;
      $display("[TB] FAIL debounce_upper_bits: got %h want 0000ffff", rd);
    end
    bus_write(OFF_IRQ_ENABLE, 32'h4);
    bus_write(OFF_DEBOUNCE, 32'h0);
    step(2);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(OFF_EDGE_RISE, 32'hF);
    bus_write(OFF_EDGE_FALL, 32'hF);
    pins_i[3:0] = 4'b0110;
    step(8);
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'hF) begin
      n_mismatched++;
      $display("[TB] FAIL all_four_pending: got %h want f", rd);
    end
    bus_write(OFF_DEBOUNCE, 32'd100);
    pins_i = 20'hF_FFFF;
    step(3);
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (irq_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset_irq: got %b want 0", irq_o);
    end
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset_pending: got %h want 0", rd);
    end
    bus_read(OFF_EDGE_RISE, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset_edge_rise: got %h want 0", rd);
    end
    bus_read(OFF_DEBOUNCE, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset_debounce: got %h want 0", rd);
    end
    @(negedge clk);
    step(2);
    rst_n = 1'b1;
    step(20);
    bus_read(OFF_PENDING, rd);
    n_compared++;
    if (rd !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_pending: got %h want 0", rd);
    end
    bus_read(OFF_PIN_STATE, rd);
    n_compared++;
    if (rd !== 32'h000F_FFFF) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_pin_state: got %h want 000fffff", rd);
    end
    n_compared++;
    if (irq_o !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_irq: got %b want 0", irq_o);
    end
  endtask

  initial begin
    clk             = 1'b0;
    rst_n           = 1'b0;
    pins_i          = '0;
    read_request_i  = 1'b0;
    write_request_i = 1'b0;
    address_i       = 32'h0;
    write_data_i    = 32'h0;
    n_compared      = 0;
    n_mismatched    = 0;
    $display("[TB] starting gpio_irq_ctrl bench");
    test_reset();
    test_basic_rise();
    test_glitch();
    test_fall_masked();
    test_back_to_back();
    test_bus();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/gpio_irq_ctrl.md
GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 20, the number of GPIO input pins monitored.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous assert, active-low.
REQ-004 SHALL have port pins_i, input, WIDTH, raw pin levels taken from the GPIO block data_out; asynchronous to clk.
REQ-005 SHALL have port read_request_i, input, 1, bus read strobe.
REQ-006 SHALL have port write_request_i, input, 1, bus write strobe.
REQ-007 SHALL have port address_i, input, 32, byte address; only bits [7:0] are decoded.
REQ-008 SHALL have port write_data_i, input, 32, write data.
REQ-009 SHALL have port read_data_o, output, 32, read data.
REQ-010 SHALL have port response_o, output, 1, bus acknowledge.
REQ-011 SHALL have port irq_o, output, 1, level interrupt to the core.

Function
REQ-012 Register map (offset, access): 0x00 IRQ_ENABLE RW; 0x04 EDGE_RISE RW; 0x08 EDGE_FALL RW; 0x0C PENDING R/W1C; 0x10 PIN_STATE RO (filtered levels); 0x14 DEBOUNCE RW (bits [15:0]).
REQ-013 response_o SHALL equal read_request_i | write_request_i combinationally; zero wait states.
REQ-014 read_data_o SHALL be combinational from the addressed register, zero-extended to 32 bits, and 32'h0 when read_request_i is low or the offset is unmapped.
REQ-015 Writes to unmapped offsets or RO registers SHALL be ignored; register bits above WIDTH (above 16 for DEBOUNCE) SHALL read 0.
REQ-016 Each pin SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 A prescaler SHALL count 0..DEBOUNCE and emit a 1-cycle tick on reaching DEBOUNCE, then wrap to 0; DEBOUNCE=0 gives a tick every cycle.
REQ-018 A write to DEBOUNCE SHALL restart the prescaler at 0.
REQ-019 On each tick, each pin SHALL shift its synchronized value into a 2-deep history (h0, h1) and SHALL update its filtered level to the synchronized value only when synchronized value, h0 and h1 are all equal.
REQ-020 A filtered 0->1 change on pin i with EDGE_RISE[i]=1, or a 1->0 change with EDGE_FALL[i]=1, SHALL set PENDING[i] on the same edge the filtered level changes.
REQ-021 Writing 1 to PENDING bit i SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-022 If a set event and a W1C clear of the same bit occur on the same edge, the set SHALL win.
REQ-023 PENDING SHALL latch regardless of IRQ_ENABLE; irq_o SHALL be a register loaded every cycle with |(PENDING & IRQ_ENABLE), i.e. one cycle after PENDING.
REQ-024 With DEBOUNCE=0 and a stable pin change, the filtered level and PENDING SHALL change on the 5th rising edge after the edge that first samples the new level, and irq_o SHALL assert on the 6th.
REQ-025 Pulses shorter than 3 consecutive ticks SHALL NOT change the filtered level or set PENDING.

Reset
REQ-026 While rst_n=0, all registers, synchronizers, histories, filtered levels, the prescaler, and irq_o SHALL be 0; read_data_o and response_o follow only REQ-013/014.
REQ-027 Because EDGE_RISE/EDGE_FALL reset to 0, pins held high at reset release SHALL NOT set PENDING.

Structure
REQ-028 Register offsets and the DEBOUNCE width SHALL be constants in the shared gpio package, reused by GPIO software headers.
REQ-029 The per-pin synchronizer+history+filter SHALL be one sub-module, gpio_filter, instantiated WIDTH times with a shared tick input.
REQ-030 The block SHALL be compiled under a GPIO_IRQ_ENABLE guard in config.vh, alongside GPIO_ENABLE.

Verification
REQ-031 Reset, write IRQ_ENABLE=1, EDGE_RISE=1, DEBOUNCE=0, drive pins_i[0] 0->1 -> PENDING=0x1 on edge 5, irq_o=1 on edge 6, PIN_STATE=0x1.
REQ-032 DEBOUNCE=3, 2-cycle high glitch on pins_i[3] -> PENDING stays 0, PIN_STATE[3] stays 0; 20-cycle high -> PENDING[3]=1.
REQ-033 EDGE_FALL=0x4, IRQ_ENABLE=0, pins_i[2] 1->0 -> PENDING=0x4, irq_o=0; then IRQ_ENABLE=0x4 -> irq_o=1 next cycle.
REQ-034 Write PENDING=0x4 on the same edge a new event sets bit 2 -> PENDING[2] remains 1; later write 0x4 alone -> PENDING=0, irq_o=0 next cycle.
REQ-035 Read offset 0x18 and read with read_request_i=0 -> read_data_o=0; write 0x10 -> PIN_STATE unchanged; response_o high exactly during strobes.
REQ-036 Assert rst_n low mid-debounce with PENDING=0xF -> all outputs/registers 0 immediately, no PENDING set after release with pins high.
